// File: rtl/rtc_hms_counter_if.sv
// rtc_hms_counter_if: button/tick inputs and BCD time outputs of the time-of-day counter
//   i_tick_1hz_in     1 Hz square wave from the divider (treated as data, not a clock)
//   i_btn_start_stop  single-cycle pulse, toggles STOP/RUN
//   i_btn_mode        single-cycle pulse, steps SET_HR -> SET_MIN -> RUN
//   i_btn_inc         single-cycle pulse, increments the field being set
//   o_*_ones/o_*_tens BCD digits hh:mm:ss
//   o_state           00=STOP 01=RUN 10=SET_HR 11=SET_MIN
//   o_sec_tick        one-cycle pulse when seconds advance
//   o_day_wrap        one-cycle pulse on 23:59:59 -> 00:00:00
interface rtc_hms_counter_if;
  logic       i_tick_1hz_in;
  logic       i_btn_start_stop;
  logic       i_btn_mode;
  logic       i_btn_inc;
  logic [3:0] o_sec_ones;
  logic [3:0] o_sec_tens;
  logic [3:0] o_min_ones;
  logic [3:0] o_min_tens;
  logic [3:0] o_hr_ones;
  logic [3:0] o_hr_tens;
  logic [1:0] o_state;
  logic       o_sec_tick;
  logic       o_day_wrap;
  modport slave (
    input  i_tick_1hz_in, i_btn_start_stop, i_btn_mode, i_btn_inc,
    output o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_hr_ones, o_hr_tens,
           o_state, o_sec_tick, o_day_wrap
  );
  modport master (
    output i_tick_1hz_in, i_btn_start_stop, i_btn_mode, i_btn_inc,
    input  o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_hr_ones, o_hr_tens,
           o_state, o_sec_tick, o_day_wrap
  );
endinterface

// File: rtl/rtc_hms_counter.sv
// rtc_hms_counter: 24-hour BCD hh:mm:ss time-of-day counter with run/stop and hour/minute set mode
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      rtc_hms_counter_if.slave: 1 Hz tick and buttons in, BCD digits/state/pulses out
module rtc_hms_counter #(
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset_n,
  rtc_hms_counter_if.slave bus
);
  typedef enum logic [1:0] {STOP = 2'b00, RUN = 2'b01, SET_HR = 2'b10, SET_MIN = 2'b11} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync, r_fill;
  logic r_prev;
  logic [3:0] r_so, r_st, r_mo, r_mt, r_ho, r_ht;
  logic r_sec_tick, r_day_wrap;
  logic w_synced, w_tick, w_run_tick, w_c_st, w_c_min, w_c_hr, w_inc_min, w_c_mt, w_inc_hr, w_h23, w_clr_sec;
  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_tick = w_synced & ~r_prev;
  // r_prev is held at 1 until the synchroniser has filled after reset, so an input
  // already high at reset release is not mistaken for a rising edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sync <= '0;
      r_fill <= '0;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_tick_1hz_in};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= w_synced | ~r_fill[SYNC_STAGES-1];
    end
  // btn_mode has priority; start/stop only acts in STOP and RUN
  always_comb begin
    w_next = r_state;
    if (bus.i_btn_mode)
      w_next = r_state == SET_HR ? SET_MIN : r_state == SET_MIN ? RUN : SET_HR;
    else if (bus.i_btn_start_stop && !r_state[1])
      w_next = r_state == RUN ? STOP : RUN;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= STOP;
    else r_state <= w_next;
  // Carry chain; in set states the selected field wraps without carrying onward
  always_comb begin
    w_run_tick = r_state == RUN && w_tick;
    w_c_st = w_run_tick && r_so == 4'd9;
    w_c_min = w_c_st && r_st == 4'd5;
    w_c_hr = w_c_min && r_mo == 4'd9 && r_mt == 4'd5;
    w_inc_min = w_c_min || (r_state == SET_MIN && bus.i_btn_inc);
    w_c_mt = w_inc_min && r_mo == 4'd9;
    w_inc_hr = w_c_hr || (r_state == SET_HR && bus.i_btn_inc);
    w_h23 = r_ht == 4'd2 && r_ho == 4'd3;
    w_clr_sec = r_state == SET_MIN && bus.i_btn_mode;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_so <= '0;
      r_st <= '0;
      r_mo <= '0;
      r_mt <= '0;
      r_ho <= '0;
      r_ht <= '0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
    end else begin
      if (w_clr_sec) begin
        r_so <= '0;
        r_st <= '0;
      end else begin
        if (w_run_tick) r_so <= r_so == 4'd9 ? 4'd0 : r_so + 4'd1;
        if (w_c_st) r_st <= r_st == 4'd5 ? 4'd0 : r_st + 4'd1;
      end
      if (w_inc_min) r_mo <= r_mo == 4'd9 ? 4'd0 : r_mo + 4'd1;
      if (w_c_mt) r_mt <= r_mt == 4'd5 ? 4'd0 : r_mt + 4'd1;
      if (w_inc_hr) begin
        r_ho <= (w_h23 || r_ho == 4'd9) ? 4'd0 : r_ho + 4'd1;
        r_ht <= w_h23 ? 4'd0 : r_ho == 4'd9 ? r_ht + 4'd1 : r_ht;
      end
      r_sec_tick <= w_run_tick;
      r_day_wrap <= w_c_hr && w_h23;
    end
  assign bus.o_sec_ones = r_so;
  assign bus.o_sec_tens = r_st;
  assign bus.o_min_ones = r_mo;
  assign bus.o_min_tens = r_mt;
  assign bus.o_hr_ones = r_ho;
  assign bus.o_hr_tens = r_ht;
  assign bus.o_state = r_state;
  assign bus.o_sec_tick = r_sec_tick;
  assign bus.o_day_wrap = r_day_wrap;
endmodule

// File: tb/tb_rtc_hms_counter.sv
// tb_rtc_hms_counter: scoreboard bench for rtc_hms_counter; expected time/latency queued per tick
module tb_rtc_hms_counter;
  localparam logic [1:0] ST_STOP = 2'd0, ST_RUN = 2'd1, ST_HR = 2'd2, ST_MIN = 2'd3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  rtc_hms_counter_if bus();
  rtc_hms_counter #(.SYNC_STAGES(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [23:0] t; logic w; int due;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, wraps = 0, seen = 0;
  int mh = 0, mm = 0, msec = 0;
  logic [1:0] mst = ST_STOP;
  logic [23:0] obs;
  assign obs = {bus.o_hr_tens, bus.o_hr_ones, bus.o_min_tens, bus.o_min_ones, bus.o_sec_tens, bus.o_sec_ones};
  function automatic logic [23:0] bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (reset_n) begin
      if (bus.o_day_wrap) wraps++;
      if (bus.o_sec_tick) begin
        seen++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sec_tick: got sec_tick=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = q.pop_front();
          checks += 3;
          if (obs !== e.t) begin errors++; $display("FAIL tick_digits: got %h expected %h", obs, e.t); end
          if (bus.o_day_wrap !== e.w) begin errors++; $display("FAIL tick_day_wrap: got %b expected %b", bus.o_day_wrap, e.w); end
          if (cyc !== e.due) begin errors++; $display("FAIL tick_latency: got cycle %0d expected %0d", cyc, e.due); end
        end
      end else if (bus.o_day_wrap) begin
        checks++;
        errors++;
        $display("FAIL wrap_without_tick: got day_wrap=1 sec_tick=0, expected day_wrap=0");
      end
    end
  task automatic advance_push();
    logic w;
    msec++;
    if (msec == 60) begin msec = 0; mm++; end
    if (mm == 60) begin mm = 0; mh++; end
    w = mh == 24;
    if (w) mh = 0;
    q.push_back('{bcd(mh, mm, msec), w, cyc + 3});
  endtask
  task automatic tick(input int hi, input int lo);
    @(negedge clk);
    bus.i_tick_1hz_in = 1'b1;
    if (mst == ST_RUN) advance_push();
    repeat (hi) @(negedge clk);
    bus.i_tick_1hz_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask
  task automatic press(input logic ss, input logic md, input logic inc);
    @(negedge clk);
    bus.i_btn_start_stop = ss;
    bus.i_btn_mode = md;
    bus.i_btn_inc = inc;
    if (inc && mst == ST_HR) mh = (mh + 1) % 24;
    if (inc && mst == ST_MIN) mm = (mm + 1) % 60;
    if (md) begin
      if (mst == ST_MIN) msec = 0;
      mst = mst == ST_HR ? ST_MIN : mst == ST_MIN ? ST_RUN : ST_HR;
    end else if (ss && !mst[1]) mst = mst == ST_RUN ? ST_STOP : ST_RUN;
    @(negedge clk);
    bus.i_btn_start_stop = 1'b0;
    bus.i_btn_mode = 1'b0;
    bus.i_btn_inc = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    q.delete();
    mh = 0; mm = 0; msec = 0; mst = ST_STOP;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending sec_tick, expected 0", name, q.size());
      q.delete();
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (obs !== 24'h0) begin errors++; $display("FAIL reset_digits: got %h expected 000000", obs); end
    if (bus.o_state !== ST_STOP) begin errors++; $display("FAIL reset_state: got %b expected 00", bus.o_state); end
    if (bus.o_sec_tick !== 1'b0) begin errors++; $display("FAIL reset_sec_tick: got %b expected 0", bus.o_sec_tick); end
    if (bus.o_day_wrap !== 1'b0) begin errors++; $display("FAIL reset_day_wrap: got %b expected 0", bus.o_day_wrap); end
    reset_n = 1'b1;
  endtask
  task automatic test_run_five();
    int s0;
    do_reset();
    press(1, 0, 0);
    s0 = seen;
    repeat (5) tick(2, 2);
    wait_drain("run5");
    checks += 3;
    if (obs !== bcd(0, 0, 5)) begin errors++; $display("FAIL run5_digits: got %h expected %h", obs, bcd(0, 0, 5)); end
    if (seen - s0 !== 5) begin errors++; $display("FAIL run5_pulses: got %0d expected 5", seen - s0); end
    if (bus.o_state !== ST_RUN) begin errors++; $display("FAIL run5_state: got %b expected 01", bus.o_state); end
  endtask
  task automatic test_set_and_wrap();
    int w0;
    do_reset();
    press(1, 0, 0);
    repeat (3) tick(2, 2);
    wait_drain("pre_set");
    press(0, 1, 0);
    checks++;
    if (bus.o_state !== ST_HR) begin errors++; $display("FAIL set_hr_state: got %b expected 10", bus.o_state); end
    repeat (23) press(0, 0, 1);
    checks++;
    if (obs !== bcd(23, 0, 3)) begin errors++; $display("FAIL set_hr_23: got %h expected %h", obs, bcd(23, 0, 3)); end
    press(0, 0, 1);
    checks++;
    if (obs !== bcd(0, 0, 3)) begin errors++; $display("FAIL set_hr_wrap: got %h expected %h", obs, bcd(0, 0, 3)); end
    repeat (23) press(0, 0, 1);
    press(1, 0, 0);
    repeat (2) tick(2, 2);
    repeat (5) @(negedge clk);
    checks += 2;
    if (obs !== bcd(23, 0, 3)) begin errors++; $display("FAIL set_hr_ticks: got %h expected %h", obs, bcd(23, 0, 3)); end
    if (bus.o_state !== ST_HR) begin errors++; $display("FAIL set_hr_ss_ignored: got %b expected 10", bus.o_state); end
    press(0, 1, 0);
    repeat (59) press(0, 0, 1);
    checks++;
    if (obs !== bcd(23, 59, 3)) begin errors++; $display("FAIL set_min_59: got %h expected %h", obs, bcd(23, 59, 3)); end
    press(0, 0, 1);
    checks++;
    if (obs !== bcd(23, 0, 3)) begin errors++; $display("FAIL set_min_wrap: got %h expected %h", obs, bcd(23, 0, 3)); end
    repeat (59) press(0, 0, 1);
    repeat (2) tick(2, 2);
    repeat (5) @(negedge clk);
    press(0, 1, 0);
    checks += 2;
    if (obs !== bcd(23, 59, 0)) begin errors++; $display("FAIL exit_set_min: got %h expected %h", obs, bcd(23, 59, 0)); end
    if (bus.o_state !== ST_RUN) begin errors++; $display("FAIL exit_state: got %b expected 01", bus.o_state); end
    repeat (58) tick(2, 2);
    wait_drain("to58");
    checks++;
    if (obs !== bcd(23, 59, 58)) begin errors++; $display("FAIL at_58: got %h expected %h", obs, bcd(23, 59, 58)); end
    w0 = wraps;
    repeat (2) tick(2, 2);
    wait_drain("wrap");
    checks += 2;
    if (obs !== 24'h0) begin errors++; $display("FAIL wrap_digits: got %h expected 000000", obs); end
    if (wraps - w0 !== 1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", wraps - w0); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    press(1, 1, 0);
    checks++;
    if (bus.o_state !== ST_HR) begin errors++; $display("FAIL mode_wins: got %b expected 10", bus.o_state); end
    press(0, 1, 1);
    checks += 2;
    if (bus.o_state !== ST_MIN) begin errors++; $display("FAIL inc_mode_state: got %b expected 11", bus.o_state); end
    if (obs !== bcd(1, 0, 0)) begin errors++; $display("FAIL inc_mode_field: got %h expected %h", obs, bcd(1, 0, 0)); end
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 1, 0);
    press(0, 0, 1);
    checks += 2;
    if (obs !== bcd(1, 1, 0)) begin errors++; $display("FAIL inc_in_run: got %h expected %h", obs, bcd(1, 1, 0)); end
    if (bus.o_state !== ST_RUN) begin errors++; $display("FAIL sim_run_state: got %b expected 01", bus.o_state); end
    @(negedge clk);
    bus.i_tick_1hz_in = 1'b1;
    advance_push();
    repeat (2) @(negedge clk);
    bus.i_btn_start_stop = 1'b1;
    mst = ST_STOP;
    @(negedge clk);
    bus.i_btn_start_stop = 1'b0;
    @(negedge clk);
    bus.i_tick_1hz_in = 1'b0;
    wait_drain("tick_ss");
    checks += 2;
    if (bus.o_state !== ST_STOP) begin errors++; $display("FAIL tick_ss_state: got %b expected 00", bus.o_state); end
    if (obs !== bcd(1, 1, 1)) begin errors++; $display("FAIL tick_ss_digits: got %h expected %h", obs, bcd(1, 1, 1)); end
    repeat (2) tick(2, 2);
    repeat (5) @(negedge clk);
    checks++;
    if (obs !== bcd(1, 1, 1)) begin errors++; $display("FAIL stop_ignores_tick: got %h expected %h", obs, bcd(1, 1, 1)); end
  endtask
  task automatic test_reset_high();
    int s0;
    @(negedge clk);
    bus.i_tick_1hz_in = 1'b1;
    reset_n = 1'b0;
    q.delete();
    mh = 0; mm = 0; msec = 0;
    repeat (3) @(negedge clk);
    s0 = seen;
    reset_n = 1'b1;
    bus.i_btn_start_stop = 1'b1;
    mst = ST_RUN;
    @(negedge clk);
    bus.i_btn_start_stop = 1'b0;
    repeat (20) @(negedge clk);
    checks += 2;
    if (obs !== 24'h0) begin errors++; $display("FAIL high_at_release_digits: got %h expected 000000", obs); end
    if (seen !== s0) begin errors++; $display("FAIL high_at_release_pulses: got %0d expected 0", seen - s0); end
    bus.i_tick_1hz_in = 1'b0;
    repeat (3) @(negedge clk);
    tick(2, 2);
    wait_drain("after_release");
    checks++;
    if (obs !== bcd(0, 0, 1)) begin errors++; $display("FAIL first_edge_after_release: got %h expected %h", obs, bcd(0, 0, 1)); end
  endtask
  task automatic test_async_reset();
    do_reset();
    press(0, 1, 0);
    repeat (12) press(0, 0, 1);
    press(0, 1, 0);
    repeat (34) press(0, 0, 1);
    press(0, 1, 0);
    repeat (56) tick(2, 2);
    wait_drain("to_123456");
    checks++;
    if (obs !== bcd(12, 34, 56)) begin errors++; $display("FAIL at_123456: got %h expected %h", obs, bcd(12, 34, 56)); end
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks += 2;
    if (obs !== 24'h0) begin errors++; $display("FAIL async_reset_digits: got %h expected 000000", obs); end
    if (bus.o_state !== ST_STOP) begin errors++; $display("FAIL async_reset_state: got %b expected 00", bus.o_state); end
    q.delete();
    mh = 0; mm = 0; msec = 0; mst = ST_STOP;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic test_long_high();
    int s0;
    do_reset();
    press(1, 0, 0);
    s0 = seen;
    tick(2000, 2);
    wait_drain("long_high");
    checks += 2;
    if (obs !== bcd(0, 0, 1)) begin errors++; $display("FAIL long_high_digits: got %h expected %h", obs, bcd(0, 0, 1)); end
    if (seen - s0 !== 1) begin errors++; $display("FAIL long_high_pulses: got %0d expected 1", seen - s0); end
  endtask
  task automatic test_free_run();
    int w0;
    do_reset();
    press(0, 1, 0);
    repeat (23) press(0, 0, 1);
    press(0, 1, 0);
    press(0, 1, 0);
    w0 = wraps;
    repeat (3600) tick(2, 2);
    wait_drain("free_run");
    checks += 2;
    if (obs !== 24'h0) begin errors++; $display("FAIL free_run_digits: got %h expected 000000", obs); end
    if (wraps - w0 !== 1) begin errors++; $display("FAIL free_run_wraps: got %0d expected 1", wraps - w0); end
  endtask
  initial begin
    bus.i_tick_1hz_in = 1'b0;
    bus.i_btn_start_stop = 1'b0;
    bus.i_btn_mode = 1'b0;
    bus.i_btn_inc = 1'b0;
    test_reset();
    test_run_five();
    test_set_and_wrap();
    test_simultaneous();
    test_reset_high();
    test_async_reset();
    test_long_high();
    test_free_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL timeout: got no completion by 5 ms, expected completion");
    $fatal(1);
  end
endmodule
